regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sole owner of the register file write port (write enable, write address, write data).
- Arbitrates between two write-back requesters: requester 0 is the ALU result path, requester 1 is the load/mult-div path.
- Keeps a 32-entry busy scoreboard, so issue logic can detect RAW hazards on rs/rt and WAW hazards on new destinations.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers)
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; 0 resets all state immediately
req0_valid  in  1  ALU write-back request
req0_addr  in  ADDR_W  destination register
req0_data  in  DATA_W  write data
req0_ready  out  1  request 0 accepted this cycle (combinational)
req1_valid  in  1  load/mult-div write-back request
req1_addr  in  ADDR_W  destination register
req1_data  in  DATA_W  write data
req1_ready  out  1  request 1 accepted this cycle (combinational)
rsv_valid  in  1  issue stage reserves a destination register
rsv_addr  in  ADDR_W  register to reserve
rsv_ready  out  1  reservation accepted (combinational)
rs  in  ADDR_W  source A lookup
rt  in  ADDR_W  source B lookup
rs_busy  out  1  busy[rs] (combinational)
rt_busy  out  1  busy[rt] (combinational)
wr  out  1  register file write enable (registered)
controle  out  ADDR_W  register file write address (registered)
entrada  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (reset==0, asynchronous):
  - wr=0, controle=0, entrada=0.
  - All busy bits = 0.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
  - A captured but uncommitted write is dropped.
- Handshake: a transfer occurs when reqN_valid && reqN_ready at a rising edge. Requesters hold valid, addr and data stable until ready.
- Grant, at most one per cycle:
  - Only one requester valid: it is granted.
  - Both valid, RR_MODE=1: grant the requester not equal to last_grant.
  - Both valid, RR_MODE=0: grant requester 0.
  - last_grant updates only on a completed transfer.
- Write pipeline, 1-cycle latency:
  - On a transfer at edge T, the output register loads wr=1, controle=addr, entrada=data. These drive the register file during cycle T+1, and the file writes at edge T+1.
  - With no transfer, wr returns to 0 at the next edge; controle and entrada hold their last values.
- Zero register:
  - A transfer with addr==0 is accepted (ready behaves normally) but loads wr=0.
  - Zero never becomes busy: rsv_addr==0 gives rsv_ready=1 and has no effect. busy[0] is hard 0.
- Scoreboard:
  - rsv_ready = !busy[rsv_addr].
  - When rsv_valid && rsv_ready at an edge, busy[rsv_addr] is set.
  - busy[controle] is cleared at the edge where wr==1, i.e. the same edge the register file commits the write.
- Simultaneous set and clear on the same address in one edge: set wins (new reservation). This is reachable only when the address was clear at the start of the cycle, so it is a defensive rule.
- A write to a register whose busy bit is already 0 is legal; the bit stays 0.
- rs_busy and rt_busy reflect the busy vector only; there is no bypass of the write in flight.
- Both requesters targeting the same address: they are serialized in grant order, so the last-granted data persists.

Test Plan:
1. Reset then idle -> wr=0, controle=0, entrada=0; all busy bits 0; rs=5 gives rs_busy=0.
2. rsv_valid with rsv_addr=8 -> rsv_ready=1 and busy[8]=1. Then req0 with addr=8, data=0xDEADBEEF -> req0_ready=1; next cycle wr=1, controle=8, entrada=0xDEADBEEF; after that edge rt=8 gives rt_busy=0.
3. RR_MODE=1, both requesters valid for 4 cycles (addr 3 and 4) -> grants in order 0,1,0,1; wr=1 for 4 consecutive cycles with controle 3,4,3,4.
4. RR_MODE=0, both requesters valid for 3 cycles -> req0_ready=1 and req1_ready=0 throughout; controle always equals req0_addr.
5. req1 with addr=0, data=0x1234 -> req1_ready=1, then wr stays 0. rsv_addr=0 -> rsv_ready=1 and rs=0 gives rs_busy=0.
6. Reserve 9 (busy[9]=1), then rsv_addr=9 again -> rsv_ready=0. Transfer to 9, then assert reset low mid-cycle while wr=1 -> wr=0 and busy vector = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and sole owner of the register file write port.
// It also holds the busy scoreboard that issue logic uses for RAW/WAW hazard checks.
module regfile_wb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit RR_MODE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              wr,
    output logic [ADDR_W-1:0] controle,
    output logic [DATA_W-1:0] entrada
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] controle_q, controle_d;
    logic [DATA_W-1:0] entrada_q, entrada_d;

    logic              pick0;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // When both requesters are valid, round-robin favours whoever did not win last.
    always_comb begin
        pick0 = 1'b1;
        if (RR_MODE) begin
            pick0 = last_grant_q;
        end
        req0_ready = req0_valid && (!req1_valid || pick0);
        req1_ready = req1_valid && !req0_ready;
    end

    always_comb begin
        xfer     = req0_ready || req1_ready;
        sel_addr = req0_ready ? req0_addr : req1_addr;
        sel_data = req0_ready ? req0_data : req1_data;

        wr_d         = xfer && (sel_addr != '0);
        controle_d   = xfer ? sel_addr : controle_q;
        entrada_d    = xfer ? sel_data : entrada_q;
        last_grant_d = last_grant_q;
        if (req0_ready) begin
            last_grant_d = 1'b0;
        end else if (req1_ready) begin
            last_grant_d = 1'b1;
        end
    end

    // Clear follows the committed write; a new reservation on the same edge wins.
    always_comb begin
        rsv_ready = !busy_q[rsv_addr];
        rs_busy   = busy_q[rs];
        rt_busy   = busy_q[rt];

        busy_d = busy_q;
        if (wr_q) begin
            busy_d[controle_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            controle_q   <= '0;
            entrada_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            controle_q   <= controle_d;
            entrada_q    <= entrada_d;
        end
    end

    assign wr       = wr_q;
    assign controle = controle_q;
    assign entrada  = entrada_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one round-robin and one fixed-priority
// instance share all inputs; each task checks its own scenario.
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid, rsv_valid;
    logic [4:0]  req0_addr, req1_addr, rsv_addr, rs, rt;
    logic [31:0] req0_data, req1_data;

    logic        rr_req0_ready, rr_req1_ready, rr_rsv_ready, rr_rs_busy, rr_rt_busy, rr_wr;
    logic [4:0]  rr_controle;
    logic [31:0] rr_entrada;
    logic        fp_req0_ready, fp_req1_ready, fp_rsv_ready, fp_rs_busy, fp_rt_busy, fp_wr;
    logic [4:0]  fp_controle;
    logic [31:0] fp_entrada;

    int total;
    int bad;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_MODE(1'b1)) u_rr (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rr_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rr_req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rr_rsv_ready),
        .rs(rs), .rt(rt), .rs_busy(rr_rs_busy), .rt_busy(rr_rt_busy),
        .wr(rr_wr), .controle(rr_controle), .entrada(rr_entrada)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_MODE(1'b0)) u_fp (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(fp_rsv_ready),
        .rs(rs), .rt(rt), .rs_busy(fp_rs_busy), .rt_busy(fp_rt_busy),
        .wr(fp_wr), .controle(fp_controle), .entrada(fp_entrada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge so registered outputs are settled.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        rsv_valid  = 1'b0; rsv_addr  = '0;
        rs = '0; rt = '0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (rr_wr !== 1'b0 || rr_controle !== 5'd0 || rr_entrada !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_rr: got wr=%b controle=%0d entrada=%h, want 0/0/0", rr_wr, rr_controle, rr_entrada);
        end
        total++;
        if (fp_wr !== 1'b0 || fp_controle !== 5'd0 || fp_entrada !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_fp: got wr=%b controle=%0d entrada=%h, want 0/0/0", fp_wr, fp_controle, fp_entrada);
        end
        reset = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            #1;
            total++;
            if (rr_rs_busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_busy_%0d: got %b, want 0", i, rr_rs_busy);
            end
        end
        rs = 5'd5;
        #1;
        total++;
        if (rr_rs_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rs5: got rs_busy=%b, want 0", rr_rs_busy);
        end
        step();
        total++;
        if (rr_wr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_wr: got %b, want 0", rr_wr);
        end
    endtask

    task automatic test_reserve_write();
        rsv_valid = 1'b1; rsv_addr = 5'd8; rt = 5'd8;
        #1;
        total++;
        if (rr_rsv_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rsv8_ready: got %b, want 1", rr_rsv_ready);
        end
        step();
        rsv_valid = 1'b0;
        #1;
        total++;
        if (rr_rt_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rsv8_busy: got %b, want 1", rr_rt_busy);
        end
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'hDEADBEEF;
        #1;
        total++;
        if (rr_req0_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wr8_req0_ready: got %b, want 1", rr_req0_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        total++;
        if (rr_wr !== 1'b1 || rr_controle !== 5'd8 || rr_entrada !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL wr8_out: got wr=%b controle=%0d entrada=%h, want 1/8/deadbeef", rr_wr, rr_controle, rr_entrada);
        end
        total++;
        if (rr_rt_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wr8_busy_inflight: got %b, want 1", rr_rt_busy);
        end
        step();
        total++;
        if (rr_rt_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr8_busy_cleared: got %b, want 0", rr_rt_busy);
        end
        total++;
        if (rr_wr !== 1'b0 || rr_controle !== 5'd8 || rr_entrada !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL wr8_hold: got wr=%b controle=%0d entrada=%h, want 0/8/deadbeef", rr_wr, rr_controle, rr_entrada);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_addr [4]  = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [31:0] exp_data [4]  = '{32'hA0A0_0003, 32'hB0B0_0004, 32'hA0A0_0003, 32'hB0B0_0004};
        pulse_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA0A0_0003;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hB0B0_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (rr_req0_ready !== (i % 2 == 0) || rr_req1_ready !== (i % 2 == 1)) begin
                bad++;
                $display("[TB] FAIL rr_grant_%0d: got r0=%b r1=%b, want r0=%b r1=%b", i, rr_req0_ready, rr_req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            step();
            total++;
            if (rr_wr !== 1'b1 || rr_controle !== exp_addr[i] || rr_entrada !== exp_data[i]) begin
                bad++;
                $display("[TB] FAIL rr_write_%0d: got wr=%b controle=%0d entrada=%h, want 1/%0d/%h", i, rr_wr, rr_controle, rr_entrada, exp_addr[i], exp_data[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_fixed_priority();
        pulse_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0033;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL fp_grant_%0d: got r0=%b r1=%b, want r0=1 r1=0", i, fp_req0_ready, fp_req1_ready);
            end
            step();
            total++;
            if (fp_wr !== 1'b1 || fp_controle !== 5'd3 || fp_entrada !== 32'h0000_0033) begin
                bad++;
                $display("[TB] FAIL fp_write_%0d: got wr=%b controle=%0d entrada=%h, want 1/3/00000033", i, fp_wr, fp_controle, fp_entrada);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_zero_register();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
        #1;
        total++;
        if (rr_req1_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_req1_ready: got %b, want 1", rr_req1_ready);
        end
        step();
        req1_valid = 1'b0;
        #1;
        total++;
        if (rr_wr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_wr: got %b, want 0", rr_wr);
        end
        rsv_valid = 1'b1; rsv_addr = 5'd0; rs = 5'd0;
        #1;
        total++;
        if (rr_rsv_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_rsv_ready: got %b, want 1", rr_rsv_ready);
        end
        step();
        rsv_valid = 1'b0;
        #1;
        total++;
        if (rr_rs_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_busy: got %b, want 0", rr_rs_busy);
        end
    endtask

    task automatic test_reset_midcycle();
        rsv_valid = 1'b1; rsv_addr = 5'd9; rs = 5'd9;
        step();
        #1;
        total++;
        if (rr_rs_busy !== 1'b1 || rr_rsv_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rsv9_again: got busy=%b rsv_ready=%b, want busy=1 rsv_ready=0", rr_rs_busy, rr_rsv_ready);
        end
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0999;
        step();
        req0_valid = 1'b0;
        #1;
        total++;
        if (rr_wr !== 1'b1 || rr_rs_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset: got wr=%b busy9=%b, want wr=1 busy9=1", rr_wr, rr_rs_busy);
        end
        reset = 1'b0;
        #1;
        total++;
        if (rr_wr !== 1'b0 || rr_controle !== 5'd0 || rr_entrada !== 32'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_out: got wr=%b controle=%0d entrada=%h, want 0/0/0", rr_wr, rr_controle, rr_entrada);
        end
        total++;
        if (rr_rs_busy !== 1'b0 || rr_rsv_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_reset_busy: got busy9=%b rsv_ready=%b, want busy9=0 rsv_ready=1", rr_rs_busy, rr_rsv_ready);
        end
        #1 reset = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_reserve_write();
        test_round_robin();
        test_fixed_priority();
        test_zero_register();
        test_reset_midcycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
